my_dmux8way16_stream: RTL and testbench

MY_DMUX8WAY16_STREAM -- requirements
Module: my_dmux8way16_stream

---
 rtl/my_dmux8way16_stream_pkg.sv | 13 +
 rtl/my_dmux8way16_stream_if.sv | 25 ++
 rtl/my_dslot16.sv | 39 +++
 rtl/my_dmux8way16_stream.sv | 56 +++++
 tb/tb_my_dmux8way16_stream.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/my_dmux8way16_stream_pkg.sv
// Shared constants for the 8-way streaming demultiplexer and its channel slots.
package my_dmux8way16_stream_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 16;

  function automatic logic [NUM_CH-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [NUM_CH-1:0] v;
    v = '0;
    v[sel] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/my_dmux8way16_stream_if.sv
// Producer/consumer bus of the streaming demultiplexer: one input stream, eight output slots.
interface my_dmux8way16_stream_if
  import my_dmux8way16_stream_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] in;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [NUM_CH-1:0]       out_valid;
  logic [NUM_CH-1:0]       out_ready;
  logic [CNT_W-1:0]        count;

  modport master (
    output in, sel, in_valid, out_ready,
    input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, count
  );

  modport slave (
    input  in, sel, in_valid, out_ready,
    output in_ready, out0, out1, out2, out3, out4, out5, out6, out7, out_valid, count
  );
endinterface

// File: rtl/my_dslot16.sv
// One-entry channel slot: holds a word until its consumer takes it; a load beats a take.
module my_dslot16 #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] in,
  input  logic                    take,
  output logic signed [WIDTH-1:0] out,
  output logic                    valid
);
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = in;
      valid_d = 1'b1;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign out   = data_q;
  assign valid = valid_q;
endmodule

// File: rtl/my_dmux8way16_stream.sv
// Streaming 1-to-8 demultiplexer: routes each accepted word into the one-entry slot chosen by sel.
module my_dmux8way16_stream
  import my_dmux8way16_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   reset,
  my_dmux8way16_stream_if.slave bus
);
  logic [NUM_CH-1:0]       load_vec;
  logic [NUM_CH-1:0]       take_vec;
  logic [NUM_CH-1:0]       slot_valid;
  logic signed [WIDTH-1:0] slot_out [NUM_CH];
  logic                    accept;
  logic [CNT_W-1:0]        count_q, count_d;

  // A full slot blocks only words addressed to it; a slot being drained can refill in the same cycle.
  assign bus.in_ready = ~slot_valid[bus.sel] | bus.out_ready[bus.sel];
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    load_vec = '0;
    if (accept) load_vec = sel_onehot(bus.sel);
    take_vec = slot_valid & bus.out_ready;
    count_d  = count_q + CNT_W'(accept);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    my_dslot16 #(.WIDTH(WIDTH)) u_slot (
      .clk   (clk),
      .reset (reset),
      .load  (load_vec[i]),
      .in    (bus.in),
      .take  (take_vec[i]),
      .out   (slot_out[i]),
      .valid (slot_valid[i])
    );
  end

  assign bus.out_valid = slot_valid;
  assign bus.count     = count_q;
  assign bus.out0      = slot_out[0];
  assign bus.out1      = slot_out[1];
  assign bus.out2      = slot_out[2];
  assign bus.out3      = slot_out[3];
  assign bus.out4      = slot_out[4];
  assign bus.out5      = slot_out[5];
  assign bus.out6      = slot_out[6];
  assign bus.out7      = slot_out[7];
endmodule

// File: tb/tb_my_dmux8way16_stream.sv
// Bench for my_dmux8way16_stream: slot-array reference model, per-cycle compare, directed scenarios.
module tb_my_dmux8way16_stream;
  logic clk;
  logic reset;
  my_dmux8way16_stream_if #(.WIDTH(16)) bus ();

  my_dmux8way16_stream #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: eight held words with full flags, plus accept count.
  bit          mval  [8];
  logic [15:0] mdata [8];
  logic [15:0] mcount;

  logic [15:0] outs [8];
  always_comb begin
    outs[0] = bus.out0; outs[1] = bus.out1; outs[2] = bus.out2; outs[3] = bus.out3;
    outs[4] = bus.out4; outs[5] = bus.out5; outs[6] = bus.out6; outs[7] = bus.out7;
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = mval[i];
    return v;
  endfunction

  function automatic bit model_ready();
    return !mval[bus.sel] || bus.out_ready[bus.sel];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      mval[i]  = 1'b0;
      mdata[i] = 16'h0;
    end
    mcount = 16'h0;
  endtask

  // One clock: predict from the inputs before the edge, commit after it.
  task automatic tick();
    bit          acc;
    bit          nval  [8];
    logic [15:0] ndata [8];
    acc = bus.in_valid && model_ready();
    for (int i = 0; i < 8; i++) begin
      nval[i]  = mval[i];
      ndata[i] = mdata[i];
      if (acc && (int'(bus.sel) == i)) begin
        nval[i]  = 1'b1;
        ndata[i] = bus.in;
      end else if (mval[i] && bus.out_ready[i]) begin
        nval[i]  = 1'b0;
      end
    end
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        mval[i]  = nval[i];
        mdata[i] = ndata[i];
      end
      if (acc) mcount = mcount + 16'd1;
    end
    #1;
  endtask

  task automatic drive(input bit v, input int s, input logic [15:0] d, input logic [7:0] r);
    bus.in_valid  = v;
    bus.sel       = 3'(s);
    bus.in        = d;
    bus.out_ready = r;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    model_clear();
    #1;
    chk("rst_out_valid", {8'h0, bus.out_valid}, 16'h0000);
    chk("rst_count", bus.count, 16'h0000);
    chk("rst_in_ready", {15'h0, bus.in_ready}, 16'h0001);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cyc_out_valid", {8'h0, bus.out_valid}, {8'h0, model_valid()});
      chk("cyc_count", bus.count, mcount);
      chk("cyc_in_ready", {15'h0, bus.in_ready}, {15'h0, model_ready()});
      for (int i = 0; i < 8; i++)
        if (mval[i]) chk("cyc_data", outs[i], mdata[i]);
    end
  end

  initial begin
    logic [15:0] c0;
    reset = 1'b0;
    model_clear();
    drive(1'b1, 0, 16'h5555, 8'h00);
    #1 reset = 1'b1;
    #1;
    chk("por_out_valid", {8'h0, bus.out_valid}, 16'h0000);
    chk("por_count", bus.count, 16'h0000);
    chk("por_out0", outs[0], 16'h0000);
    chk("por_in_ready", {15'h0, bus.in_ready}, 16'h0001);
    tick();
    chk("rst_no_accept", bus.count, 16'h0000);
    #3 reset = 1'b0;
    drive(1'b0, 0, 16'h0, 8'h00);
    tick();

    // Single word to channel 5.
    drive(1'b1, 5, 16'h1234, 8'h00);
    tick();
    drive(1'b0, 0, 16'h0, 8'h00);
    chk("r30_out_valid", {8'h0, bus.out_valid}, 16'h0020);
    chk("r30_out5", outs[5], 16'h1234);
    chk("r30_count", bus.count, 16'h0001);
    drive(1'b0, 0, 16'h0, 8'hFF);
    tick();

    // Full channel 3 stalls only its own traffic.
    drive(1'b1, 3, 16'h3333, 8'h00);
    tick();
    c0 = bus.count;
    drive(1'b1, 3, 16'h4444, 8'h00);
    #1 chk("r31_in_ready", {15'h0, bus.in_ready}, 16'h0000);
    tick();
    chk("r31_no_accept", bus.count, c0);
    chk("r31_out3_held", outs[3], 16'h3333);
    drive(1'b1, 6, 16'hBEEF, 8'h00);
    #1 chk("r31_in_ready6", {15'h0, bus.in_ready}, 16'h0001);
    tick();
    chk("r31_out_valid", {8'h0, bus.out_valid}, 16'h0048);
    chk("r31_out6", outs[6], 16'hBEEF);
    drive(1'b0, 0, 16'h0, 8'hFF);
    tick();

    // Load beats take: channel 2 streams one word per cycle.
    drive(1'b1, 2, 16'h0011, 8'h00);
    tick();
    drive(1'b1, 2, 16'h00AA, 8'h04);
    #1 chk("r32_in_ready", {15'h0, bus.in_ready}, 16'h0001);
    tick();
    chk("r32_valid2", {15'h0, bus.out_valid[2]}, 16'h0001);
    chk("r32_out2", outs[2], 16'h00AA);
    c0 = bus.count;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2, 16'hC000 + 16'(k), 8'h04);
      tick();
      chk("r32_stream", outs[2], 16'hC000 + 16'(k));
    end
    chk("r32_four_words", bus.count - c0, 16'd4);
    drive(1'b0, 0, 16'h0, 8'hFF);
    tick();

    // Fill all channels, drain them together.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k, 16'hA0 + 16'(k), 8'h00);
      tick();
    end
    drive(1'b0, 0, 16'h0, 8'h00);
    chk("r33_full", {8'h0, bus.out_valid}, 16'h00FF);
    chk("r33_count", bus.count, 16'd8);
    chk("r33_out7", outs[7], 16'h00A7);
    drive(1'b0, 0, 16'h0, 8'hFF);
    tick();
    chk("r33_empty", {8'h0, bus.out_valid}, 16'h0000);
    chk("r33_count_after", bus.count, 16'd8);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
            16'($urandom), 8'($urandom));
      tick();
    end

    // Async reset between edges with channels 1 and 7 full.
    drive(1'b1, 1, 16'h1111, 8'h00);
    tick();
    drive(1'b1, 7, 16'h7777, 8'h00);
    tick();
    drive(1'b0, 0, 16'h0, 8'h00);
    chk("r35_pre", {8'h0, bus.out_valid & 8'h82}, 16'h0082);
    do_reset();
    chk("r35_out1", outs[1], 16'h0000);
    drive(1'b1, 1, 16'h2222, 8'h00);
    tick();
    drive(1'b0, 0, 16'h0, 8'hFF);
    chk("r35_out_valid", {8'h0, bus.out_valid}, 16'h0002);
    chk("r35_count", bus.count, 16'h0001);
    tick();

    // Counter wrap: reach 0xFFFF then one more accept.
    do_reset();
    for (int k = 0; k < 65535; k++) begin
      drive(1'b1, k % 8, 16'(k), 8'hFF);
      tick();
    end
    chk("r34_ffff", bus.count, 16'hFFFF);
    drive(1'b1, 4, 16'h4242, 8'hFF);
    tick();
    drive(1'b0, 0, 16'h0, 8'h00);
    chk("r34_wrap", bus.count, 16'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
